jt12_timers: RTL and testbench

Timer A / Timer B block of the JT12 FM core. Consumes the timer clock-enable produced by the clock divider, runs the two programmable YM2612-style interval timers, and drives the status flags and the active-low interrupt line read by the CPU interface. Also provides the Timer A overflow strobe that the channel logic uses for CSM key-on.

---
 rtl/jt12_timers_if.sv | 28 ++
 rtl/jt12_timers.sv | 114 +++++++++++
 tb/tb_jt12_timers.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/jt12_timers_if.sv
// Register-side bus of the JT12 timer block: presets, run bits, IRQ controls and status.
interface jt12_timers_if;
  logic       clk_en;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A;
  logic       load_B;
  logic       enable_irq_A;
  logic       enable_irq_B;
  logic       clr_flag_A;
  logic       clr_flag_B;
  logic       flag_A;
  logic       flag_B;
  logic       overflow_A;
  logic       irq_n;

  modport master (
    output clk_en, value_A, value_B, load_A, load_B,
           enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B,
    input  flag_A, flag_B, overflow_A, irq_n
  );

  modport slave (
    input  clk_en, value_A, value_B, load_A, load_B,
           enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B,
    output flag_A, flag_B, overflow_A, irq_n
  );
endinterface

// File: rtl/jt12_timers.sv
// YM2612-style Timer A / Timer B with status flags and active-low IRQ.
// Define JT12_TIMER_CSM_EN to drive the Timer A overflow strobe used for CSM key-on.
module jt12_timers (
  input logic          clk,
  input logic          rst,
  jt12_timers_if.slave bus
);
  localparam int unsigned AW = 10;
  localparam int unsigned BW = 8;
  localparam int unsigned PW = 4;

  logic [AW-1:0] cnt_a, cnt_a_nxt;
  logic [BW-1:0] cnt_b, cnt_b_nxt;
  logic [PW-1:0] pre_b, pre_b_nxt;
  logic          load_a_last, load_a_last_nxt;
  logic          load_b_last, load_b_last_nxt;
  logic          flag_a, flag_a_nxt;
  logic          flag_b, flag_b_nxt;
  logic          ovf_a_c, ovf_b_c;

  // Timer A: reload on run-bit rising edge, count up to 1023 then reload and overflow
  always_comb begin
    cnt_a_nxt       = cnt_a;
    load_a_last_nxt = load_a_last;
    ovf_a_c         = 1'b0;
    if (bus.clk_en) begin
      load_a_last_nxt = bus.load_A;
      if (bus.load_A) begin
        if (!load_a_last) begin
          cnt_a_nxt = bus.value_A;
        end else if (cnt_a == '1) begin
          cnt_a_nxt = bus.value_A;
          ovf_a_c   = 1'b1;
        end else begin
          cnt_a_nxt = cnt_a + AW'(1);
        end
      end
    end
  end

  // Timer B: same scheme behind a divide-by-16 prescaler
  always_comb begin
    cnt_b_nxt       = cnt_b;
    pre_b_nxt       = pre_b;
    load_b_last_nxt = load_b_last;
    ovf_b_c         = 1'b0;
    if (bus.clk_en) begin
      load_b_last_nxt = bus.load_B;
      if (bus.load_B) begin
        if (!load_b_last) begin
          cnt_b_nxt = bus.value_B;
          pre_b_nxt = '0;
        end else begin
          pre_b_nxt = pre_b + PW'(1);
          if (pre_b == '1) begin
            if (cnt_b == '1) begin
              cnt_b_nxt = bus.value_B;
              ovf_b_c   = 1'b1;
            end else begin
              cnt_b_nxt = cnt_b + BW'(1);
            end
          end
        end
      end
    end
  end

  // Flags: an enabled overflow outranks a clear request in the same cycle
  always_comb begin
    flag_a_nxt = flag_a;
    flag_b_nxt = flag_b;
    if (bus.clr_flag_A)              flag_a_nxt = 1'b0;
    if (ovf_a_c && bus.enable_irq_A) flag_a_nxt = 1'b1;
    if (bus.clr_flag_B)              flag_b_nxt = 1'b0;
    if (ovf_b_c && bus.enable_irq_B) flag_b_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a       <= '0;
      cnt_b       <= '0;
      pre_b       <= '0;
      load_a_last <= 1'b0;
      load_b_last <= 1'b0;
      flag_a      <= 1'b0;
      flag_b      <= 1'b0;
    end else begin
      cnt_a       <= cnt_a_nxt;
      cnt_b       <= cnt_b_nxt;
      pre_b       <= pre_b_nxt;
      load_a_last <= load_a_last_nxt;
      load_b_last <= load_b_last_nxt;
      flag_a      <= flag_a_nxt;
      flag_b      <= flag_b_nxt;
    end
  end

`ifdef JT12_TIMER_CSM_EN
  logic overflow_a;

  always_ff @(posedge clk) begin
    if (rst) overflow_a <= 1'b0;
    else     overflow_a <= ovf_a_c;
  end

  assign bus.overflow_A = overflow_a;
`else
  assign bus.overflow_A = 1'b0;
`endif

  assign bus.flag_A = flag_a;
  assign bus.flag_B = flag_b;
  assign bus.irq_n  = ~(flag_a | flag_b);
endmodule

// File: tb/tb_jt12_timers.sv
// Directed bench for jt12_timers: scoreboarded flag/strobe/irq checks after each step.
module tb_jt12_timers;
`ifdef JT12_TIMER_CSM_EN
  localparam bit CSM = 1'b1;
`else
  localparam bit CSM = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [3:0] exp;  // {flag_A, flag_B, overflow_A, irq_n}
  } sb_entry_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;
  sb_entry_t sb_q[$];

  jt12_timers_if bus ();

  jt12_timers dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; clk_en driven on the falling edge, outputs settle 1 time unit after the rising edge
  task automatic cyc(input logic en);
    @(negedge clk);
    bus.clk_en = en;
    @(posedge clk);
    #1;
  endtask

  // n timer ticks, each preceded by an idle clock; returns just after the last tick edge
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic expect_out(input string tag, input logic fa, input logic fb, input logic oa);
    sb_entry_t e;
    e.tag = tag;
    e.exp = {fa, fb, oa & CSM, ~(fa | fb)};
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    sb_entry_t  e;
    logic [3:0] obs;
    e   = sb_q.pop_front();
    obs = {bus.flag_A, bus.flag_B, bus.overflow_A, bus.irq_n};
    n_checks++;
    assert (obs === e.exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed {fA,fB,ovA,irq_n}=%b expected %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic chk(input string tag, input logic fa, input logic fb, input logic oa);
    expect_out(tag, fa, fb, oa);
    check_out();
  endtask

  initial begin
    rst              = 1'b1;
    bus.clk_en       = 1'b0;
    bus.value_A      = 10'd0;
    bus.value_B      = 8'd0;
    bus.load_A       = 1'b1;
    bus.load_B       = 1'b1;
    bus.enable_irq_A = 1'b1;
    bus.enable_irq_B = 1'b1;
    bus.clr_flag_A   = 1'b0;
    bus.clr_flag_B   = 1'b0;

    // Reset held with ticks arriving and both timers requested to run
    for (int i = 0; i < 4; i++) begin
      cyc(1'(i % 2 == 0));
      chk("reset", 1'b0, 1'b0, 1'b0);
    end

    // Timer A period 4; load_A held through reset is a rising edge on the first tick
    bus.value_A = 10'd1020;
    bus.load_B  = 1'b0;
    rst         = 1'b0;
    ticks(1);
    chk("a_load_tick", 1'b0, 1'b0, 1'b0);
    ticks(3);
    chk("a_tick3", 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk("a_ovf1", 1'b1, 1'b0, 1'b1);
    cyc(1'b0);
    chk("a_strobe_one_clk", 1'b1, 1'b0, 1'b0);
    bus.clr_flag_A = 1'b1;
    cyc(1'b0);
    bus.clr_flag_A = 1'b0;
    chk("a_clear", 1'b0, 1'b0, 1'b0);
    ticks(3);
    chk("a_tick7", 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk("a_ovf2", 1'b1, 1'b0, 1'b1);

    // Clear held across an overflow tick: set wins, cleared the clock after
    bus.clr_flag_A = 1'b1;
    cyc(1'b0);
    chk("a_clr_held", 1'b0, 1'b0, 1'b0);
    ticks(3);
    chk("a_clr_tick11", 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk("a_set_wins", 1'b1, 1'b0, 1'b1);
    cyc(1'b0);
    chk("a_clr_after_set", 1'b0, 1'b0, 1'b0);
    bus.clr_flag_A = 1'b0;

    // Timer B period 32 ticks
    bus.load_A       = 1'b0;
    bus.enable_irq_A = 1'b0;
    bus.value_B      = 8'd254;
    bus.load_B       = 1'b1;
    ticks(1);
    chk("b_load_tick", 1'b0, 1'b0, 1'b0);
    ticks(31);
    chk("b_tick31", 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk("b_ovf", 1'b0, 1'b1, 1'b0);
    bus.clr_flag_B = 1'b1;
    cyc(1'b0);
    bus.clr_flag_B = 1'b0;
    chk("b_clear_irq", 1'b0, 1'b0, 1'b0);
    bus.load_B = 1'b0;

    // Timer A at 1023 with irq disabled: strobe every tick, flag untouched
    bus.value_A = 10'd1023;
    bus.load_A  = 1'b1;
    ticks(1);
    chk("a1023_load", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      chk("a1023_ovf", 1'b0, 1'b0, 1'b1);
      cyc(1'b0);
      chk("a1023_gap", 1'b0, 1'b0, 1'b0);
    end

    // Stop at cnt_A=1000, restart 5 ticks later: counting resumes from the preset
    bus.load_A = 1'b0;
    ticks(1);
    bus.value_A      = 10'd24;
    bus.enable_irq_A = 1'b1;
    bus.load_A       = 1'b1;
    ticks(1);
    ticks(976);
    chk("a_at_1000", 1'b0, 1'b0, 1'b0);
    bus.load_A = 1'b0;
    ticks(5);
    chk("a_stopped", 1'b0, 1'b0, 1'b0);
    bus.load_A = 1'b1;
    ticks(1);
    ticks(24);
    chk("a_reloaded", 1'b0, 1'b0, 1'b0);
    ticks(975);
    chk("a_pre_ovf", 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk("a_restart_ovf", 1'b1, 1'b0, 1'b1);

    // Reset mid-count overrides a simultaneous tick
    rst = 1'b1;
    cyc(1'b1);
    chk("reset_mid", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
